// File: rtl/stream_mux_2_pkg.sv
// stream_mux_2_pkg: shared state encodings and source IDs for the stream mux/demux pair.
package stream_mux_2_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;
    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;
endpackage

// File: rtl/rr_arb_2.sv
// rr_arb_2: two-way round-robin arbiter with optional packet locking.
module rr_arb_2
    import stream_mux_2_pkg::*;
#(
    parameter bit LOCK_PKT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       xfer,
    input  logic       xfer_last,
    output logic [1:0] gnt
);
    logic [1:0] state;
    logic       ptr;
    logic       src;

    // A locked owner keeps its grant even while it has nothing to send.
    always_comb
        gnt = state == ST_LOCK0 ? 2'b01 :
              state == ST_LOCK1 ? 2'b10 :
              {req[1] & (!req[0] | ptr), req[0] & (!req[1] | !ptr)};

    assign src = gnt[1];

    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= SRC0;
        end else if (xfer) begin
            if (!LOCK_PKT || xfer_last) begin
                state <= ST_IDLE;
                ptr   <= !src;
            end else begin
                state <= src ? ST_LOCK1 : ST_LOCK0;
            end
        end
endmodule

// File: rtl/stream_mux_2.sv
// stream_mux_2: 2:1 valid/ready stream merge with round-robin arbitration and a registered output.
module stream_mux_2
    import stream_mux_2_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit LOCK_PKT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);
    logic       load;
    logic       xfer;
    logic       xfer_last;
    logic [1:0] gnt;

    assign load      = !out_valid | out_ready;
    assign in0_ready = load & gnt[0] & rst_n;
    assign in1_ready = load & gnt[1] & rst_n;
    assign xfer      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
    assign xfer_last = gnt[1] ? in1_last : in0_last;

    rr_arb_2 #(.LOCK_PKT(LOCK_PKT)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({in1_valid, in0_valid}),
        .xfer      (xfer),
        .xfer_last (xfer_last),
        .gnt       (gnt)
    );

    always_ff @(posedge clk)
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= SRC0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt[1] ? in1_data : in0_data;
            out_last  <= xfer_last;
            out_src   <= gnt[1] ? SRC1 : SRC0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_stream_mux_2.sv
// tb_stream_mux_2: directed and random checks of stream_mux_2 against a cycle reference model.
module tb_stream_mux_2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in0_valid = 1'b0, in0_last = 1'b0, in1_valid = 1'b0, in1_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in0_data = '0, in1_data = '0;
    logic in0_ready, in1_ready, out_valid, out_last, out_src;
    logic [7:0] out_data;

    int n_chk = 0, n_fail = 0;
    int m_owner = -1;
    logic m_ptr = 1'b0, m_ov = 1'b0, m_ol = 1'b0, m_os = 1'b0, m_known = 1'b0;
    logic [7:0] m_od = '0;
    logic [7:0] got_d[$];
    logic got_s[$];

    stream_mux_2 #(.WIDTH(8), .LOCK_PKT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance the model across the edge.
    task automatic cyc(input logic r, input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1, input logic ordy);
        int win;
        logic load, r0, r1;
        rst_n = r; in0_valid = v0; in0_data = d0; in0_last = l0;
        in1_valid = v1; in1_data = d1; in1_last = l1; out_ready = ordy;
        #2;
        load = !m_ov || ordy;
        win  = m_owner >= 0 ? m_owner : (v0 && v1) ? int'(m_ptr) : v0 ? 0 : v1 ? 1 : -1;
        r0   = r && load && win == 0;
        r1   = r && load && win == 1;
        chk("in0_ready", in0_ready, r0);
        chk("in1_ready", in1_ready, r1);
        if (m_known) begin
            chk("out_valid", out_valid, m_ov);
            chk("out_data", out_data, m_od);
            chk("out_last", out_last, m_ol);
            chk("out_src", out_src, m_os);
        end
        if (out_valid === 1'b1 && ordy) begin
            got_d.push_back(out_data);
            got_s.push_back(out_src);
        end
        @(posedge clk);
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_ov = 0; m_od = 0; m_ol = 0; m_os = 0; m_known = 1;
        end else if ((r0 && v0) || (r1 && v1)) begin
            m_ov = 1;
            m_od = r1 ? d1 : d0;
            m_ol = r1 ? l1 : l0;
            m_os = r1;
            m_owner = m_ol ? -1 : int'(r1);
            if (m_ol) m_ptr = !r1;
        end else if (ordy) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    endtask

    task automatic rst2();
        cyc(0, 1, 8'h00, 0, 1, 8'h00, 0, 1);
        cyc(0, 1, 8'h00, 0, 1, 8'h00, 0, 1);
    endtask

    initial begin
        rst2();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_src", out_src, 0);

        cyc(1, 1, 8'hA5, 1, 0, 8'h00, 0, 1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_src", out_src, 0);
        chk("single_last", out_last, 1);
        idle(1);

        rst2();
        got_d.delete(); got_s.delete();
        for (int i = 0; i < 4; i++) cyc(1, 1, 8'h11, 1, 1, 8'h22, 1, 1);
        idle(2);
        chk("cont_len", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            chk("cont_data", got_d[i], (i % 2) ? 8'h22 : 8'h11);
            chk("cont_src", got_s[i], i % 2);
        end

        got_d.delete(); got_s.delete();
        for (int i = 1; i <= 3; i++) cyc(1, 1, 8'(i), i == 3, 1, 8'h99, 1, 1);
        cyc(1, 0, 8'h00, 0, 1, 8'h99, 1, 1);
        idle(2);
        chk("lock_len", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            chk("lock_data", got_d[i], i == 3 ? 8'h99 : 8'(i + 1));
            chk("lock_src", got_s[i], i == 3);
        end

        got_d.delete(); got_s.delete();
        cyc(1, 1, 8'h5A, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 8'h6B, 1, 1, 8'h7C, 1, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h5A);
            chk("bp_src", out_src, 0);
            chk("bp_last", out_last, 1);
        end
        cyc(1, 1, 8'h6B, 1, 1, 8'h7C, 1, 1);
        cyc(1, 1, 8'h6B, 1, 0, 8'h00, 0, 1);
        idle(2);
        chk("bp_len", got_d.size(), 3);
        if (got_d.size() == 3) begin
            chk("bp_seq0", got_d[0], 8'h5A);
            chk("bp_seq1", got_d[1], 8'h7C);
            chk("bp_seq2", got_d[2], 8'h6B);
        end

        cyc(1, 0, 8'h00, 0, 1, 8'hE1, 0, 1);
        cyc(0, 1, 8'h00, 0, 1, 8'hE2, 0, 1);
        chk("mid_rst_valid", out_valid, 0);
        got_d.delete(); got_s.delete();
        for (int i = 0; i < 2; i++) cyc(1, 1, 8'hC0, 1, 1, 8'hD1, 1, 1);
        idle(2);
        chk("mid_len", got_d.size(), 2);
        if (got_d.size() == 2) begin
            chk("mid_first", got_d[0], 8'hC0);
            chk("mid_second", got_d[1], 8'hD1);
            chk("mid_src", got_s[0], 0);
        end

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 40) != 0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
